jtframe_sdram_arb: RTL and testbench



---
 rtl/jtframe_sdram_arb_pkg.sv | 20 ++
 rtl/jtframe_sdram_arb_if.sv | 41 ++++
 rtl/jtframe_rr_pick.sv | 28 ++
 rtl/jtframe_sdram_arb.sv | 98 +++++++++
 tb/tb_jtframe_sdram_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and widths for the SDRAM port arbiter.
package jtframe_sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DOUTW = 32;  // controller read data width
  localparam int MASKW = 2;   // byte mask width for writes
  localparam int WDW   = 16;  // write data width

  // Round-robin successor of slot i among n slots
  function automatic int rr_next(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// Requester-side and controller-side bus of the SDRAM arbiter.
// master: the arbiter's view. slave: the environment (requesters + controller).
interface jtframe_sdram_arb_if
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22
);
  // requester side
  logic [SLOTS-1:0]       slot_req;
  logic [SLOTS*AW-1:0]    slot_addr;
  logic [SLOTS-1:0]       slot_rnw;
  logic [SLOTS*MASKW-1:0] slot_wrmask;
  logic [SLOTS*WDW-1:0]   slot_din;
  logic [SLOTS-1:0]       slot_dok;
  logic [DOUTW-1:0]       slot_dout;
  // controller side
  logic                   sdram_req;
  logic                   sdram_ack;
  logic [AW-1:0]          sdram_addr;
  logic                   sdram_rnw;
  logic [MASKW-1:0]       sdram_wrmask;
  logic [WDW-1:0]         data_write;
  logic [DOUTW-1:0]       data_read;
  logic                   data_rdy;

  modport master (
    input  slot_req, slot_addr, slot_rnw, slot_wrmask, slot_din,
    input  sdram_ack, data_read, data_rdy,
    output slot_dok, slot_dout,
    output sdram_req, sdram_addr, sdram_rnw, sdram_wrmask, data_write
  );

  modport slave (
    output slot_req, slot_addr, slot_rnw, slot_wrmask, slot_din,
    output sdram_ack, data_read, data_rdy,
    input  slot_dok, slot_dout,
    input  sdram_req, sdram_addr, sdram_rnw, sdram_wrmask, data_write
  );

endinterface

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: first requesting slot at or after ptr, wrapping.
module jtframe_rr_pick #(
  parameter int SLOTS = 4,
  parameter int IW    = $clog2(SLOTS)
)(
  input  logic [SLOTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan from the farthest offset down so the nearest requester is written last
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= SLOTS) j = j - SLOTS;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM controller port among SLOTS requesters.
// One transaction in flight; a watchdog aborts a transaction whose data_rdy never comes.
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int TOUT  = 255
)(
  input  logic                clk_rom,
  input  logic                rst,
  input  logic                downloading,
  output logic                tout_err,
  jtframe_sdram_arb_if.master bus
);

  localparam int         IW    = $clog2(SLOTS);
  localparam logic [7:0] TOUT8 = 8'(TOUT);

  state_t        st;
  logic [IW-1:0] ptr, winner, pick_idx;
  logic          pick_vld;
  logic [7:0]    wd;

  jtframe_rr_pick #(.SLOTS(SLOTS), .IW(IW)) u_pick (
    .req   (bus.slot_req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Arbitration FSM; all bus outputs are registered copies latched at grant time
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      st               <= IDLE;
      ptr              <= '0;
      winner           <= '0;
      wd               <= '0;
      tout_err         <= 1'b0;
      bus.sdram_req    <= 1'b0;
      bus.sdram_addr   <= '0;
      bus.sdram_rnw    <= 1'b0;
      bus.sdram_wrmask <= '0;
      bus.data_write   <= '0;
      bus.slot_dok     <= '0;
      bus.slot_dout    <= '0;
    end else begin
      bus.slot_dok <= '0;
      case (st)
        IDLE: begin
          if (!downloading && pick_vld) begin
            winner           <= pick_idx;
            bus.sdram_addr   <= bus.slot_addr[int'(pick_idx)*AW +: AW];
            bus.sdram_rnw    <= bus.slot_rnw[pick_idx];
            bus.sdram_wrmask <= bus.slot_wrmask[int'(pick_idx)*MASKW +: MASKW];
            bus.data_write   <= bus.slot_din[int'(pick_idx)*WDW +: WDW];
            bus.sdram_req    <= 1'b1;
            st               <= REQ;
          end
        end
        REQ: begin
          if (bus.sdram_ack) begin
            bus.sdram_req <= 1'b0;
            wd            <= '0;
            if (bus.data_rdy) begin
              // controller finished in the same cycle it accepted
              if (bus.sdram_rnw) bus.slot_dout <= bus.data_read;
              bus.slot_dok[winner] <= 1'b1;
              st <= DONE;
            end else begin
              st <= WAIT;
            end
          end
        end
        WAIT: begin
          // data_rdy takes precedence over the watchdog expiring
          if (bus.data_rdy) begin
            if (bus.sdram_rnw) bus.slot_dout <= bus.data_read;
            bus.slot_dok[winner] <= 1'b1;
            st <= DONE;
          end else if (wd == TOUT8) begin
            tout_err <= 1'b1;
            st       <= IDLE;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        DONE: begin
          // served slot drops to lowest priority
          ptr <= IW'(rr_next(int'(winner), SLOTS));
          st  <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Directed + randomized bench for jtframe_sdram_arb with a behavioural arbitration model.
module tb_jtframe_sdram_arb;
  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int TOUT  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic downloading = 1'b0;
  logic tout_err;

  jtframe_sdram_arb_if #(.SLOTS(SLOTS), .AW(AW)) bus ();

  jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .TOUT(TOUT)) dut (
    .clk_rom     (clk),
    .rst         (rst),
    .downloading (downloading),
    .tout_err    (tout_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state: round-robin pointer, last read data, per-slot request contents
  int             ptr_m;
  logic [31:0]    dout_m;
  logic [AW-1:0]  addr_m [SLOTS];
  logic           rnw_m  [SLOTS];
  logic [1:0]     mask_m [SLOTS];
  logic [15:0]    din_m  [SLOTS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // first requesting slot at or after the pointer, wrapping
  function automatic int pick_m(input logic [SLOTS-1:0] r);
    for (int k = 0; k < SLOTS; k++)
      if (r[(ptr_m + k) % SLOTS]) return (ptr_m + k) % SLOTS;
    return -1;
  endfunction

  task automatic set_slot(input int i, input logic rnw, input logic [AW-1:0] a,
                          input logic [1:0] m, input logic [15:0] d);
    rnw_m[i]  = rnw;
    addr_m[i] = a;
    mask_m[i] = m;
    din_m[i]  = d;
    bus.slot_rnw[i]             = rnw;
    bus.slot_addr[i*AW +: AW]   = a;
    bus.slot_wrmask[i*2 +: 2]   = m;
    bus.slot_din[i*16 +: 16]    = d;
  endtask

  task automatic wait_grant(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.sdram_req === 1'b1) begin
        ok  = 1'b1;
        lat = n;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL grant_timeout: observed no sdram_req expected sdram_req within 40 cycles");
    end
  endtask

  // One full transaction as seen from the controller side.
  task automatic txn(input int ack_dly, input int rdy_dly, input logic [31:0] rdata,
                     input bit same, input logic [SLOTS-1:0] keep, input bit drop_served,
                     output int w, output int lat);
    bit ok;
    logic [SLOTS-1:0] oh;
    w = pick_m(bus.slot_req);
    wait_grant(ok, lat);
    if (!ok || w < 0) return;
    check("sdram_addr",   64'(bus.sdram_addr),   64'(addr_m[w]));
    check("sdram_rnw",    64'(bus.sdram_rnw),    64'(rnw_m[w]));
    check("sdram_wrmask", 64'(bus.sdram_wrmask), 64'(mask_m[w]));
    check("data_write",   64'(bus.data_write),   64'(din_m[w]));
    for (int n = 0; n < ack_dly; n++) begin
      @(negedge clk);
      check("sdram_req_hold", 64'(bus.sdram_req), 64'(1));
    end
    bus.sdram_ack = 1'b1;
    if (same) begin
      bus.data_rdy  = 1'b1;
      bus.data_read = rdata;
    end
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    if (!same) begin
      check("sdram_req_drop", 64'(bus.sdram_req), 64'(0));
      for (int n = 0; n < rdy_dly; n++) begin
        @(negedge clk);
        check("dok_early", 64'(bus.slot_dok), 64'(0));
      end
      bus.data_rdy  = 1'b1;
      bus.data_read = rdata;
      @(negedge clk);
    end
    bus.data_rdy  = 1'b0;
    bus.data_read = $urandom;
    if (rnw_m[w]) dout_m = rdata;
    oh    = '0;
    oh[w] = 1'b1;
    check("slot_dok", 64'(bus.slot_dok), 64'(oh));
    check("slot_dout", 64'(bus.slot_dout), 64'(dout_m));
    bus.slot_req = bus.slot_req & keep;
    if (drop_served) bus.slot_req[w] = 1'b0;
    ptr_m = (w + 1) % SLOTS;
    @(negedge clk);
    check("dok_single", 64'(bus.slot_dok), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, lat, first, n;
    bit ok, dok_seen;
    bus.slot_req = '0; bus.slot_addr = '0; bus.slot_rnw = '0;
    bus.slot_wrmask = '0; bus.slot_din = '0;
    bus.sdram_ack = 1'b0; bus.data_read = '0; bus.data_rdy = 1'b0;
    for (int i = 0; i < SLOTS; i++) set_slot(i, 1'b1, '0, 2'b00, 16'h0);
    ptr_m = 0;
    dout_m = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_sdram_req",  64'(bus.sdram_req),    64'(0));
    check("rst_sdram_addr", 64'(bus.sdram_addr),   64'(0));
    check("rst_wrmask",     64'(bus.sdram_wrmask), 64'(0));
    check("rst_data_write", 64'(bus.data_write),   64'(0));
    check("rst_dok",        64'(bus.slot_dok),     64'(0));
    check("rst_dout",       64'(bus.slot_dout),    64'(0));
    check("rst_tout_err",   64'(tout_err),         64'(0));
    rst = 1'b0;

    // single read from slot 1
    @(negedge clk);
    set_slot(1, 1'b1, 22'h12345, 2'b00, 16'h0);
    bus.slot_req = 4'b0010;
    txn(2, 5, 32'hDEADBEEF, 1'b0, '0, 1'b0, w, lat);
    check("read1_slot", 64'(w), 64'(1));
    check("read1_latency", 64'(lat), 64'(1));
    check("read1_dout", 64'(bus.slot_dout), 64'(32'hDEADBEEF));

    // all four slots request continuously: consecutive grants, one dok each
    for (int i = 0; i < SLOTS; i++) set_slot(i, 1'b1, AW'($urandom), 2'($urandom), 16'($urandom));
    bus.slot_req = 4'b1111;
    first = -1;
    for (int g = 0; g < 5; g++) begin
      txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'b0,
          (g == 4) ? 4'b0000 : 4'b1111, 1'b0, w, lat);
      if (g == 0) first = w;
      else check("rr_order", 64'(w), 64'((first + g) % SLOTS));
    end

    // slot 2 write: read data register must not change
    set_slot(2, 1'b0, AW'($urandom), 2'b01, 16'hA55A);
    bus.slot_req = 4'b0100;
    n = int'(dout_m);
    txn(1, 3, 32'h0BADF00D, 1'b0, '0, 1'b0, w, lat);
    check("write_slot", 64'(w), 64'(2));
    check("write_dout_kept", 64'(bus.slot_dout), 64'(32'(n)));

    // watchdog: ack given, data_rdy withheld
    set_slot(3, 1'b1, AW'($urandom), 2'b00, 16'h0);
    bus.slot_req = 4'b1000;
    wait_grant(ok, lat);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    dok_seen = 1'b0;
    n = 0;
    while (tout_err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.slot_dok != 0) dok_seen = 1'b1;
    end
    check("wd_tout_err", 64'(tout_err), 64'(1));
    check("wd_no_dok", 64'(dok_seen), 64'(0));
    check("wd_cycles_in_range", 64'(n >= TOUT && n <= TOUT + 2), 64'(1));
    txn(1, 2, $urandom, 1'b0, '0, 1'b0, w, lat);
    check("wd_next_served", 64'(w), 64'(3));
    check("wd_sticky", 64'(tout_err), 64'(1));

    // downloading blocks new grants
    downloading = 1'b1;
    set_slot(0, 1'b1, AW'($urandom), 2'b00, 16'h0);
    bus.slot_req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("dl_no_req", 64'(bus.sdram_req), 64'(0));
    end
    downloading = 1'b0;
    txn(0, 1, $urandom, 1'b0, '0, 1'b0, w, lat);
    check("dl_grant_latency", 64'(lat), 64'(1));

    // randomized traffic, including ack+data_rdy together
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < SLOTS; i++)
        if (!bus.slot_req[i])
          set_slot(i, 1'($urandom), AW'($urandom), 2'($urandom), 16'($urandom));
      bus.slot_req = bus.slot_req | 4'($urandom_range(1, 15));
      txn($urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'($urandom),
          4'b1111, 1'b1, w, lat);
    end
    for (int g = 0; g < SLOTS && bus.slot_req != 0; g++)
      txn(1, 1, $urandom, 1'b0, 4'b1111, 1'b1, w, lat);

    // reset in WAIT after slot 1 was served (pointer would favour slot 2)
    set_slot(1, 1'b1, AW'($urandom), 2'b00, 16'h0);
    bus.slot_req = 4'b0010;
    txn(0, 0, $urandom, 1'b0, '0, 1'b0, w, lat);
    set_slot(2, 1'b1, AW'($urandom), 2'b00, 16'h0);
    bus.slot_req = 4'b0100;
    wait_grant(ok, lat);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw_sdram_req", 64'(bus.sdram_req), 64'(0));
    check("rstw_dok",       64'(bus.slot_dok),  64'(0));
    check("rstw_tout_err",  64'(tout_err),      64'(0));
    @(negedge clk);
    rst = 1'b0;
    ptr_m  = 0;
    dout_m = '0;
    set_slot(0, 1'b1, AW'($urandom), 2'b00, 16'h0);
    bus.slot_req = 4'b0101;
    txn(1, 1, $urandom, 1'b0, 4'b1111, 1'b1, w, lat);
    check("rstw_first_slot0", 64'(w), 64'(0));
    txn(1, 1, $urandom, 1'b0, 4'b1111, 1'b1, w, lat);
    check("rstw_then_slot2", 64'(w), 64'(2));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
